// File: rtl/exhaustive_sweep_capture_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared definitions for the exhaustive sweep capture block:
//   - sweep_state_t : sequencer states
//   - DEFAULT_POLY  : default MISR feedback polynomial (CRC-16-CCITT taps)
//   - gray_of()     : binary-to-Gray conversion used for Gray-ordered sweeps
// -----------------------------------------------------------------------------
package sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } sweep_state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // Sweep index is at most 16 bits wide; callers truncate to their width.
  function automatic logic [15:0] gray_of(input logic [15:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/exhaustive_sweep_capture_misr.sv
// -----------------------------------------------------------------------------
// misr_reg
// Multiple-input signature register. Each enabled cycle shifts the signature
// left, applies POLY feedback when the outgoing MSB is set, and XORs in the
// zero-extended input word.
// Ports:
//   CK    in   clock, rising edge
//   reset in   asynchronous active-low reset (loads SEED)
//   clr   in   synchronous reload of SEED (has priority over en)
//   en    in   fold din into the signature this edge
//   din   in   DIN_W-bit word to fold in
//   sig   out  current signature
// -----------------------------------------------------------------------------
module misr_reg
  import sweep_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               DIN_W = 1,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = {sig[SIG_W-2:0], 1'b0}
            ^ (sig[SIG_W-1] ? POLY : '0)
            ^ SIG_W'(din);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      sig <= SEED;
    end else if (clr) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/exhaustive_sweep_capture.sv
// -----------------------------------------------------------------------------
// exhaustive_sweep_capture
// Walks every 2^N_IN input vector (binary or Gray order) into a circuit under
// test, waits SETTLE_CYC cycles, samples the response once, streams each
// (vector, response) record over valid/ready and folds the response into a
// MISR signature.
// Ports:
//   CK        in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   begin a sweep from IDLE or DONE
//   abort     in   return to IDLE, clear outputs and signature (beats start)
//   stim_out  out  registered vector to the circuit under test
//   resp_in   in   response from the circuit under test
//   cap_valid out  capture record valid
//   cap_ready in   logger accepts record
//   cap_vec   out  vector the record belongs to
//   cap_resp  out  sampled response
//   busy      out  high in DRIVE/SETTLE/CAPTURE
//   done      out  high while in DONE
//   sig       out  MISR signature, final once done is high
// -----------------------------------------------------------------------------
module exhaustive_sweep_capture
  import sweep_pkg::*;
#(
  parameter int               N_IN       = 3,
  parameter int               N_OUT      = 1,
  parameter int               SETTLE_CYC = 1,
  parameter int               GRAY       = 0,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED       = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  stim_out,
  input  logic [N_OUT-1:0] resp_in,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [N_IN-1:0]  cap_vec,
  output logic [N_OUT-1:0] cap_resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig
);

  // One extra index bit keeps the terminal compare unambiguous at N_IN=16.
  localparam logic [N_IN:0] LAST_IDX  = {1'b0, {N_IN{1'b1}}};
  localparam logic [7:0]    SETTLE_LD = 8'(SETTLE_CYC);

  sweep_state_t  state;
  logic [N_IN:0] idx;
  logic [N_IN:0] idx_nxt;
  logic [7:0]    settle_cnt;
  logic          sweep_start;
  logic          cap_take;
  logic          misr_clr;

  function automatic logic [N_IN-1:0] vec_of(input logic [N_IN:0] i);
    logic [15:0] w;
    logic [15:0] g;
    w = 16'(i[N_IN-1:0]);
    g = (GRAY != 0) ? gray_of(w) : w;
    return g[N_IN-1:0];
  endfunction

  assign idx_nxt     = idx + {{N_IN{1'b0}}, 1'b1};
  assign sweep_start = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  // Edge that enters CAPTURE: straight from DRIVE with no settle time,
  // otherwise the last SETTLE cycle.
  assign cap_take    = !abort &&
                       (((state == S_DRIVE) && (SETTLE_CYC == 0)) ||
                        ((state == S_SETTLE) && (settle_cnt == 8'd1)));
  assign misr_clr    = abort || sweep_start;

  misr_reg #(
    .SIG_W (SIG_W),
    .DIN_W (N_OUT),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .CK    (CK),
    .reset (reset),
    .clr   (misr_clr),
    .en    (cap_take),
    .din   (resp_in),
    .sig   (sig)
  );

  // stim_out is loaded on the edge that enters DRIVE, so the circuit under
  // test already sees the new vector during DRIVE. This gives a meaningful
  // sample even with SETTLE_CYC=0, and cap_vec can copy stim_out directly.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      stim_out   <= '0;
      cap_vec    <= '0;
      cap_resp   <= '0;
      cap_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      stim_out   <= '0;
      cap_vec    <= '0;
      cap_resp   <= '0;
      cap_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (sweep_start) begin
            idx      <= '0;
            stim_out <= vec_of('0);
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          settle_cnt <= SETTLE_LD;
          if (cap_take) begin
            cap_resp  <= resp_in;
            cap_vec   <= stim_out;
            cap_valid <= 1'b1;
            state     <= S_CAPTURE;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cap_take) begin
            cap_resp  <= resp_in;
            cap_vec   <= stim_out;
            cap_valid <= 1'b1;
            state     <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          if (cap_ready) begin
            cap_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx      <= idx_nxt;
              stim_out <= vec_of(idx_nxt);
              state    <= S_DRIVE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_sweep_capture
// Three DUT instances: binary order with one settle cycle (u0), Gray order with
// one settle cycle (u1), binary order with no settle cycle (u2). Each drives a
// small combinational circuit model; handshaken records from whichever
// instance is active are collected and compared with hand-computed tables.
// -----------------------------------------------------------------------------
module tb_exhaustive_sweep_capture;

  typedef struct {
    logic [2:0] vec;
    logic       resp;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [3];
  logic        abort_v [3];
  logic [2:0]  stim    [3];
  logic        resp_v  [3];
  logic        cv      [3];
  logic        cr      [3];
  logic [2:0]  cvec    [3];
  logic        cresp   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] sig_v   [3];

  int          n_vec = 0;
  int          n_bad = 0;
  logic [3:0]  recq[$];
  rec_t        tab [3][8];

  always #5 clk = ~clk;

  // Circuits under test
  assign resp_v[0] = ^stim[0];
  assign resp_v[1] = ^stim[1];
  assign resp_v[2] = stim[2][2];

  exhaustive_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE_CYC(1), .GRAY(0)) u0 (
    .CK(clk), .reset(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .stim_out(stim[0]), .resp_in(resp_v[0]), .cap_valid(cv[0]), .cap_ready(cr[0]),
    .cap_vec(cvec[0]), .cap_resp(cresp[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sig(sig_v[0]));

  exhaustive_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE_CYC(1), .GRAY(1)) u1 (
    .CK(clk), .reset(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .stim_out(stim[1]), .resp_in(resp_v[1]), .cap_valid(cv[1]), .cap_ready(cr[1]),
    .cap_vec(cvec[1]), .cap_resp(cresp[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sig(sig_v[1]));

  exhaustive_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE_CYC(0), .GRAY(0)) u2 (
    .CK(clk), .reset(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .stim_out(stim[2]), .resp_in(resp_v[2]), .cap_valid(cv[2]), .cap_ready(cr[2]),
    .cap_vec(cvec[2]), .cap_resp(cresp[2]), .busy(busy_v[2]), .done(done_v[2]),
    .sig(sig_v[2]));

  // Record monitor: a record is taken on the edge after a negedge with valid&ready.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int w = 0; w < 3; w++) begin
        if (cv[w] && cr[w]) recq.push_back({cvec[w], cresp[w]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_recs(input int s, input string tag);
    logic [3:0] r;
    chk({tag, " record count"}, 32'(recq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      r = (i < recq.size()) ? recq[i] : 4'hx;
      chk($sformatf("%s rec%0d vec", tag, i), 32'(r[3:1]), 32'(tab[s][i].vec));
      chk($sformatf("%s rec%0d resp", tag, i), 32'(r[0]), 32'(tab[s][i].resp));
    end
  endtask

  // Pulse start for one edge, then count edges until done is seen.
  task automatic run_sweep(input int w, output int n);
    @(posedge clk); #1 start_v[w] = 1'b1;
    @(posedge clk); #1 start_v[w] = 1'b0;
    n = 0;
    while (!done_v[w] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin : main
    int         n;
    logic [7:0] rb;
    logic [7:0] rg;
    logic [7:0] rs;
    logic [2:0] gv [8];

    // Hand-computed tables: bit i of rb/rg/rs is the response of record i.
    rb = 8'h96;   // parity of 0..7: 0,1,1,0,1,0,0,1
    rg = 8'hAA;   // parity of Gray codes: 0,1,0,1,0,1,0,1
    rs = 8'hF0;   // bit 2 of 0..7: 0,0,0,0,1,1,1,1
    gv = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    for (int i = 0; i < 8; i++) begin
      tab[0][i].vec  = 3'(i);
      tab[0][i].resp = rb[i];
      tab[1][i].vec  = gv[i];
      tab[1][i].resp = rg[i];
      tab[2][i].vec  = 3'(i);
      tab[2][i].resp = rs[i];
    end

    for (int w = 0; w < 3; w++) begin
      start_v[w] = 1'b0;
      abort_v[w] = 1'b0;
      cr[w]      = 1'b1;
    end

    // Asynchronous reset before any clock edge
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset stim_out",  32'(stim[0]),   32'd0);
    chk("reset cap_valid", 32'(cv[0]),     32'd0);
    chk("reset cap_vec",   32'(cvec[0]),   32'd0);
    chk("reset cap_resp",  32'(cresp[0]),  32'd0);
    chk("reset busy",      32'(busy_v[0]), 32'd0);
    chk("reset done",      32'(done_v[0]), 32'd0);
    chk("reset sig",       32'(sig_v[0]),  32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Binary order, one settle cycle
    recq.delete();
    run_sweep(0, n);
    chk("bin done edges", 32'(n), 32'd24);
    check_recs(0, "bin");
    chk("bin sig",        32'(sig_v[0]),  32'h0069);
    chk("bin busy at end", 32'(busy_v[0]), 32'd0);
    chk("bin stim holds", 32'(stim[0]),   32'd7);

    // Gray order
    recq.delete();
    run_sweep(1, n);
    chk("gray done edges", 32'(n), 32'd24);
    check_recs(1, "gray");
    chk("gray sig",        32'(sig_v[1]), 32'h0055);
    chk("gray stim holds", 32'(stim[1]),  32'd4);

    // No settle time
    recq.delete();
    run_sweep(2, n);
    chk("s0 done edges", 32'(n), 32'd16);
    check_recs(2, "s0");
    chk("s0 sig",        32'(sig_v[2]), 32'h000F);

    // Back-pressure during the third record, restarting from DONE
    recq.delete();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    chk("stall done cleared", 32'(done_v[0]), 32'd0);
    n = 0;
    repeat (8) begin @(posedge clk); #1; n++; end
    cr[0] = 1'b0;
    chk("stall entry valid", 32'(cv[0]),   32'd1);
    chk("stall entry vec",   32'(cvec[0]), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; n++;
      chk($sformatf("stall%0d valid", k), 32'(cv[0]),   32'd1);
      chk($sformatf("stall%0d vec", k),   32'(cvec[0]), 32'd2);
      chk($sformatf("stall%0d stim", k),  32'(stim[0]), 32'd2);
    end
    cr[0] = 1'b1;
    while (!done_v[0] && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall done edges", 32'(n), 32'd29);
    check_recs(0, "stall");
    chk("stall sig", 32'(sig_v[0]), 32'h0069);

    // Abort after the fourth record, then a full restart
    recq.delete();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort records before", 32'(recq.size()), 32'd4);
    chk("abort busy before",    32'(busy_v[0]),   32'd1);
    abort_v[0] = 1'b1;
    @(posedge clk); #1 abort_v[0] = 1'b0;
    chk("abort busy",      32'(busy_v[0]), 32'd0);
    chk("abort sig",       32'(sig_v[0]),  32'h0);
    chk("abort cap_valid", 32'(cv[0]),     32'd0);
    chk("abort stim_out",  32'(stim[0]),   32'd0);
    chk("abort done",      32'(done_v[0]), 32'd0);
    recq.delete();
    run_sweep(0, n);
    chk("restart done edges", 32'(n), 32'd24);
    check_recs(0, "restart");
    chk("restart sig", 32'(sig_v[0]), 32'h0069);

    // start and abort together from DONE: abort wins
    @(posedge clk); #1 begin start_v[0] = 1'b1; abort_v[0] = 1'b1; end
    @(posedge clk); #1 begin start_v[0] = 1'b0; abort_v[0] = 1'b0; end
    chk("start+abort busy", 32'(busy_v[0]), 32'd0);
    chk("start+abort done", 32'(done_v[0]), 32'd0);
    chk("start+abort sig",  32'(sig_v[0]),  32'h0);

    // Reset pulled low between edges during SETTLE of vector 1
    recq.delete();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre-reset stim",  32'(stim[0]),   32'd1);
    chk("pre-reset busy",  32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset stim_out",  32'(stim[0]),   32'd0);
    chk("async reset cap_valid", 32'(cv[0]),     32'd0);
    chk("async reset busy",      32'(busy_v[0]), 32'd0);
    chk("async reset done",      32'(done_v[0]), 32'd0);
    chk("async reset sig",       32'(sig_v[0]),  32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full sweep after release, with start pulsed while busy
    recq.delete();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    n = 0;
    while (!done_v[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
      start_v[0] = (n == 5) || (n == 10);
    end
    start_v[0] = 1'b0;
    chk("post-reset done edges", 32'(n), 32'd24);
    check_recs(0, "post-reset");
    chk("post-reset sig", 32'(sig_v[0]), 32'h0069);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
